// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: cpu/dbg requester ports and data-memory port of the arbiter
interface dmem_arbiter_if #(
  parameter int ADDR = 32,
  parameter int DATA = 32
);
  logic            cpu_req;
  logic            cpu_we;
  logic [ADDR-1:0] cpu_addr;
  logic [DATA-1:0] cpu_wd;
  logic            cpu_stall;
  logic [DATA-1:0] cpu_rd;
  logic            cpu_rvalid;
  logic            dbg_req;
  logic            dbg_we;
  logic [ADDR-1:0] dbg_addr;
  logic [DATA-1:0] dbg_wd;
  logic            dbg_lock;
  logic            dbg_gnt;
  logic [DATA-1:0] dbg_rd;
  logic            dbg_rvalid;
  logic            mem_we;
  logic [ADDR-1:0] mem_wa;
  logic [ADDR-1:0] mem_ra;
  logic [DATA-1:0] mem_wd;
  logic [DATA-1:0] mem_rd;
  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wd,
    output cpu_stall, cpu_rd, cpu_rvalid,
    input  dbg_req, dbg_we, dbg_addr, dbg_wd, dbg_lock,
    output dbg_gnt, dbg_rd, dbg_rvalid,
    output mem_we, mem_wa, mem_ra, mem_wd,
    input  mem_rd
  );
  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wd,
    input  cpu_stall, cpu_rd, cpu_rvalid,
    output dbg_req, dbg_we, dbg_addr, dbg_wd, dbg_lock,
    input  dbg_gnt, dbg_rd, dbg_rvalid,
    input  mem_we, mem_wa, mem_ra, mem_wd,
    output mem_rd
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data memory between the MEM stage (priority) and a dbg master
module dmem_arbiter #(
  parameter int ADDR         = 32,
  parameter int DATA         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic             clk,
  input logic             rst,
  dmem_arbiter_if.master  bus
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
  localparam logic [0:0] S_ARB  = 1'b0;
  localparam logic [0:0] S_LOCK = 1'b1;
  logic [0:0]      state;
  logic [CW-1:0]   starve_cnt;
  logic            dbg_gnt;
  logic            cpu_gnt;
  logic [DATA-1:0] cpu_rd_q;
  logic [DATA-1:0] dbg_rd_q;
  logic            cpu_rvalid_q;
  logic            dbg_rvalid_q;
  logic [ADDR-1:0] addr;
  always_comb begin
    dbg_gnt = rst ? 1'b0 :
              state == S_LOCK ? bus.dbg_req :
              bus.dbg_req & (~bus.cpu_req | starve_cnt == LIMIT);
    cpu_gnt = ~rst & state == S_ARB & bus.cpu_req & ~dbg_gnt;
    addr    = dbg_gnt ? bus.dbg_addr : bus.cpu_addr;
  end
  assign bus.dbg_gnt    = dbg_gnt;
  assign bus.cpu_stall  = ~rst & bus.cpu_req & ~cpu_gnt;
  assign bus.mem_we     = (cpu_gnt & bus.cpu_we) | (dbg_gnt & bus.dbg_we);
  assign bus.mem_wa     = addr;
  assign bus.mem_ra     = addr;
  assign bus.mem_wd     = dbg_gnt ? bus.dbg_wd : bus.cpu_wd;
  assign bus.cpu_rd     = cpu_rd_q;
  assign bus.dbg_rd     = dbg_rd_q;
  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.dbg_rvalid = dbg_rvalid_q;
  // lock is released after the first cycle that presents dbg_lock low, granted or idle
  always_ff @(posedge clk) begin
    if (rst)
      state <= S_ARB;
    else if (state == S_ARB)
      state <= dbg_gnt & bus.dbg_lock ? S_LOCK : S_ARB;
    else
      state <= bus.dbg_lock ? S_LOCK : S_ARB;
  end
  always_ff @(posedge clk) begin
    if (rst || dbg_gnt || !bus.dbg_req)
      starve_cnt <= '0;
    else if (starve_cnt != LIMIT)
      starve_cnt <= starve_cnt + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      cpu_rd_q     <= '0;
      dbg_rd_q     <= '0;
    end else begin
      cpu_rvalid_q <= cpu_gnt & ~bus.cpu_we;
      dbg_rvalid_q <= dbg_gnt & ~bus.dbg_we;
      if (cpu_gnt && !bus.cpu_we)
        cpu_rd_q <= bus.mem_rd;
      if (dbg_gnt && !bus.dbg_we)
        dbg_rd_q <= bus.mem_rd;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios against a 64-word behavioural data memory
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [31:0] mem [64];
  dmem_arbiter_if bus ();
  dmem_arbiter #(.ADDR(32), .DATA(32), .STARVE_LIMIT(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always_comb bus.mem_rd = mem[bus.mem_ra[7:2]];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[4] <= 32'hDEADBEEF;
    end else if (bus.mem_we) begin
      mem[bus.mem_wa[7:2]] <= bus.mem_wd;
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic c_req, input logic c_we, input logic [31:0] c_addr, input logic [31:0] c_wd,
                       input logic d_req, input logic d_we, input logic [31:0] d_addr, input logic [31:0] d_wd,
                       input logic d_lock);
    bus.cpu_req = c_req; bus.cpu_we = c_we; bus.cpu_addr = c_addr; bus.cpu_wd = c_wd;
    bus.dbg_req = d_req; bus.dbg_we = d_we; bus.dbg_addr = d_addr; bus.dbg_wd = d_wd; bus.dbg_lock = d_lock;
  endtask
  task automatic idle();
    drive(0, 0, 32'h10, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic test_reset();
    rst = 1'b1;
    drive(1, 1, 32'h10, 32'h5, 1, 1, 32'h20, 32'h6, 1);
    cyc();
    #1;
    n_cmp++; if (bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL rst_mem_we: got %b want 0", bus.mem_we); end
    n_cmp++; if (bus.cpu_stall !== 1'b0) begin n_bad++; $display("FAIL rst_cpu_stall: got %b want 0", bus.cpu_stall); end
    n_cmp++; if (bus.dbg_gnt !== 1'b0) begin n_bad++; $display("FAIL rst_dbg_gnt: got %b want 0", bus.dbg_gnt); end
    cyc();
    rst = 1'b0;
    idle();
    #1;
    n_cmp++; if (bus.cpu_rvalid !== 1'b0) begin n_bad++; $display("FAIL rst_cpu_rvalid: got %b want 0", bus.cpu_rvalid); end
    n_cmp++; if (bus.dbg_rvalid !== 1'b0) begin n_bad++; $display("FAIL rst_dbg_rvalid: got %b want 0", bus.dbg_rvalid); end
    n_cmp++; if (bus.cpu_rd !== 32'h0) begin n_bad++; $display("FAIL rst_cpu_rd: got %h want 0", bus.cpu_rd); end
    n_cmp++; if (bus.dbg_rd !== 32'h0) begin n_bad++; $display("FAIL rst_dbg_rd: got %h want 0", bus.dbg_rd); end
    n_cmp++; if (bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL idle_mem_we: got %b want 0", bus.mem_we); end
    n_cmp++; if (bus.mem_ra !== 32'h10) begin n_bad++; $display("FAIL idle_mem_ra: got %h want 10", bus.mem_ra); end
  endtask
  task automatic test_cpu_read();
    cyc();
    drive(1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
    #1;
    n_cmp++; if (bus.cpu_stall !== 1'b0) begin n_bad++; $display("FAIL rd_stall: got %b want 0", bus.cpu_stall); end
    n_cmp++; if (bus.mem_ra !== 32'h10) begin n_bad++; $display("FAIL rd_mem_ra: got %h want 10", bus.mem_ra); end
    n_cmp++; if (bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL rd_mem_we: got %b want 0", bus.mem_we); end
    cyc();
    idle();
    #1;
    n_cmp++; if (bus.cpu_rvalid !== 1'b1) begin n_bad++; $display("FAIL rd_rvalid: got %b want 1", bus.cpu_rvalid); end
    n_cmp++; if (bus.cpu_rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_data: got %h want deadbeef", bus.cpu_rd); end
    n_cmp++; if (bus.dbg_rvalid !== 1'b0) begin n_bad++; $display("FAIL rd_dbg_rvalid: got %b want 0", bus.dbg_rvalid); end
    cyc();
    n_cmp++; if (bus.cpu_rvalid !== 1'b0) begin n_bad++; $display("FAIL rd_rvalid_drop: got %b want 0", bus.cpu_rvalid); end
    n_cmp++; if (bus.cpu_rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_hold: got %h want deadbeef", bus.cpu_rd); end
  endtask
  task automatic test_starvation();
    for (int i = 1; i <= 5; i++) begin
      cyc();
      drive(1, 0, 32'h20, 0, 1, 1, 32'h40, 32'h1234, 0);
      #1;
      n_cmp++; if (bus.dbg_gnt !== (i == 5)) begin n_bad++; $display("FAIL starve_gnt[%0d]: got %b want %b", i, bus.dbg_gnt, i == 5); end
      n_cmp++; if (bus.cpu_stall !== (i == 5)) begin n_bad++; $display("FAIL starve_stall[%0d]: got %b want %b", i, bus.cpu_stall, i == 5); end
      if (i == 5) begin
        n_cmp++; if (bus.mem_we !== 1'b1) begin n_bad++; $display("FAIL starve_mem_we: got %b want 1", bus.mem_we); end
        n_cmp++; if (bus.mem_wa !== 32'h40) begin n_bad++; $display("FAIL starve_mem_wa: got %h want 40", bus.mem_wa); end
        n_cmp++; if (bus.mem_wd !== 32'h1234) begin n_bad++; $display("FAIL starve_mem_wd: got %h want 1234", bus.mem_wd); end
      end
    end
    cyc();
    drive(1, 0, 32'h40, 0, 0, 0, 0, 0, 0);
    #1;
    n_cmp++; if (bus.cpu_stall !== 1'b0) begin n_bad++; $display("FAIL starve_rb_stall: got %b want 0", bus.cpu_stall); end
    cyc();
    idle();
    #1;
    n_cmp++; if (bus.cpu_rvalid !== 1'b1) begin n_bad++; $display("FAIL starve_rb_rvalid: got %b want 1", bus.cpu_rvalid); end
    n_cmp++; if (bus.cpu_rd !== 32'h1234) begin n_bad++; $display("FAIL starve_rb_data: got %h want 1234", bus.cpu_rd); end
  endtask
  task automatic test_lock_burst();
    int w;
    for (w = 1; w <= 8; w++) begin
      cyc();
      drive(1, 0, 32'h10, 0, 1, 1, 32'h0, 32'hA0, 1);
      #1;
      if (bus.dbg_gnt === 1'b1) break;
    end
    n_cmp++; if (w !== 5) begin n_bad++; $display("FAIL burst_first_gnt_cycle: got %0d want 5", w); end
    n_cmp++; if (bus.cpu_stall !== 1'b1) begin n_bad++; $display("FAIL burst_stall[0]: got %b want 1", bus.cpu_stall); end
    for (int k = 1; k < 4; k++) begin
      cyc();
      drive(1, 0, 32'h10, 0, 1, 1, 32'(4 * k), 32'hA0 + 32'(k), k < 3);
      #1;
      n_cmp++; if (bus.dbg_gnt !== 1'b1) begin n_bad++; $display("FAIL burst_gnt[%0d]: got %b want 1", k, bus.dbg_gnt); end
      n_cmp++; if (bus.cpu_stall !== 1'b1) begin n_bad++; $display("FAIL burst_stall[%0d]: got %b want 1", k, bus.cpu_stall); end
      n_cmp++; if (bus.mem_wa !== 32'(4 * k)) begin n_bad++; $display("FAIL burst_wa[%0d]: got %h want %h", k, bus.mem_wa, 4 * k); end
    end
    cyc();
    drive(1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
    #1;
    n_cmp++; if (bus.cpu_stall !== 1'b0) begin n_bad++; $display("FAIL burst_release_stall: got %b want 0", bus.cpu_stall); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (mem[k] !== 32'hA0 + 32'(k)) begin n_bad++; $display("FAIL burst_mem[%0d]: got %h want %h", k, mem[k], 32'hA0 + k); end
    end
  endtask
  task automatic test_back_to_back();
    cyc();
    drive(1, 0, 32'h0, 0, 0, 0, 0, 0, 0);
    cyc();
    drive(1, 0, 32'h4, 0, 0, 0, 0, 0, 0);
    #1;
    n_cmp++; if (bus.cpu_rvalid !== 1'b1) begin n_bad++; $display("FAIL b2b_rvalid0: got %b want 1", bus.cpu_rvalid); end
    n_cmp++; if (bus.cpu_rd !== 32'hA0) begin n_bad++; $display("FAIL b2b_data0: got %h want a0", bus.cpu_rd); end
    cyc();
    idle();
    #1;
    n_cmp++; if (bus.cpu_rvalid !== 1'b1) begin n_bad++; $display("FAIL b2b_rvalid1: got %b want 1", bus.cpu_rvalid); end
    n_cmp++; if (bus.cpu_rd !== 32'hA1) begin n_bad++; $display("FAIL b2b_data1: got %h want a1", bus.cpu_rd); end
    cyc();
    n_cmp++; if (bus.cpu_rvalid !== 1'b0) begin n_bad++; $display("FAIL b2b_rvalid_end: got %b want 0", bus.cpu_rvalid); end
  endtask
  task automatic test_lock_idle();
    cyc();
    drive(0, 0, 32'h10, 0, 1, 1, 32'h50, 32'h55, 1);
    #1;
    n_cmp++; if (bus.dbg_gnt !== 1'b1) begin n_bad++; $display("FAIL gap_enter_gnt: got %b want 1", bus.dbg_gnt); end
    n_cmp++; if (bus.mem_we !== 1'b1) begin n_bad++; $display("FAIL gap_enter_we: got %b want 1", bus.mem_we); end
    for (int j = 0; j < 3; j++) begin
      cyc();
      drive(1, 1, 32'h14, 32'h77, 0, 0, 0, 0, 1);
      #1;
      n_cmp++; if (bus.cpu_stall !== 1'b1) begin n_bad++; $display("FAIL gap_stall[%0d]: got %b want 1", j, bus.cpu_stall); end
      n_cmp++; if (bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL gap_mem_we[%0d]: got %b want 0", j, bus.mem_we); end
    end
    cyc();
    drive(1, 1, 32'h14, 32'h77, 1, 0, 32'h50, 0, 0);
    #1;
    n_cmp++; if (bus.dbg_gnt !== 1'b1) begin n_bad++; $display("FAIL gap_last_gnt: got %b want 1", bus.dbg_gnt); end
    n_cmp++; if (bus.cpu_stall !== 1'b1) begin n_bad++; $display("FAIL gap_last_stall: got %b want 1", bus.cpu_stall); end
    n_cmp++; if (bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL gap_last_we: got %b want 0", bus.mem_we); end
    cyc();
    drive(1, 1, 32'h14, 32'h77, 0, 0, 0, 0, 0);
    #1;
    n_cmp++; if (bus.dbg_rvalid !== 1'b1) begin n_bad++; $display("FAIL gap_dbg_rvalid: got %b want 1", bus.dbg_rvalid); end
    n_cmp++; if (bus.dbg_rd !== 32'h55) begin n_bad++; $display("FAIL gap_dbg_rd: got %h want 55", bus.dbg_rd); end
    n_cmp++; if (bus.cpu_rvalid !== 1'b0) begin n_bad++; $display("FAIL gap_cpu_rvalid: got %b want 0", bus.cpu_rvalid); end
    n_cmp++; if (bus.cpu_stall !== 1'b0) begin n_bad++; $display("FAIL gap_release_stall: got %b want 0", bus.cpu_stall); end
    n_cmp++; if (bus.mem_we !== 1'b1) begin n_bad++; $display("FAIL gap_release_we: got %b want 1", bus.mem_we); end
    cyc();
    idle();
    #1;
    n_cmp++; if (mem[5] !== 32'h77) begin n_bad++; $display("FAIL gap_cpu_write: got %h want 77", mem[5]); end
  endtask
  task automatic test_reset_mid_lock();
    cyc();
    drive(0, 0, 32'h10, 0, 1, 1, 32'h60, 32'h66, 1);
    #1;
    n_cmp++; if (bus.dbg_gnt !== 1'b1) begin n_bad++; $display("FAIL rml_enter_gnt: got %b want 1", bus.dbg_gnt); end
    cyc();
    drive(1, 0, 32'h10, 0, 1, 0, 32'h60, 0, 1);
    #1;
    n_cmp++; if (bus.cpu_stall !== 1'b1) begin n_bad++; $display("FAIL rml_locked_stall: got %b want 1", bus.cpu_stall); end
    cyc();
    rst = 1'b1;
    drive(1, 0, 32'h10, 0, 1, 1, 32'h64, 32'h99, 1);
    #1;
    n_cmp++; if (bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL rml_mem_we: got %b want 0", bus.mem_we); end
    n_cmp++; if (bus.dbg_gnt !== 1'b0) begin n_bad++; $display("FAIL rml_dbg_gnt: got %b want 0", bus.dbg_gnt); end
    n_cmp++; if (bus.cpu_stall !== 1'b0) begin n_bad++; $display("FAIL rml_cpu_stall: got %b want 0", bus.cpu_stall); end
    cyc();
    n_cmp++; if (bus.dbg_rvalid !== 1'b0) begin n_bad++; $display("FAIL rml_rvalid_dropped: got %b want 0", bus.dbg_rvalid); end
    n_cmp++; if (bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL rml_mem_we2: got %b want 0", bus.mem_we); end
    cyc();
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.cpu_stall !== 1'b0) begin n_bad++; $display("FAIL rml_cpu_first: got %b want 0", bus.cpu_stall); end
    n_cmp++; if (bus.dbg_gnt !== 1'b0) begin n_bad++; $display("FAIL rml_dbg_after: got %b want 0", bus.dbg_gnt); end
    n_cmp++; if (bus.mem_ra !== 32'h10) begin n_bad++; $display("FAIL rml_mem_ra: got %h want 10", bus.mem_ra); end
    n_cmp++; if (bus.dbg_rvalid !== 1'b0) begin n_bad++; $display("FAIL rml_dbg_rvalid: got %b want 0", bus.dbg_rvalid); end
    n_cmp++; if (bus.dbg_rd !== 32'h0) begin n_bad++; $display("FAIL rml_dbg_rd: got %h want 0", bus.dbg_rd); end
    cyc();
    idle();
    #1;
    n_cmp++; if (bus.cpu_rvalid !== 1'b1) begin n_bad++; $display("FAIL rml_cpu_rvalid: got %b want 1", bus.cpu_rvalid); end
    n_cmp++; if (bus.cpu_rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rml_cpu_rd: got %h want deadbeef", bus.cpu_rd); end
    n_cmp++; if (bus.dbg_rvalid !== 1'b0) begin n_bad++; $display("FAIL rml_dbg_rvalid2: got %b want 0", bus.dbg_rvalid); end
    n_cmp++; if (mem[25] !== 32'h0) begin n_bad++; $display("FAIL rml_no_write: got %h want 0", mem[25]); end
  endtask
  initial begin
    idle();
    test_reset();
    test_cpu_read();
    test_starvation();
    test_lock_burst();
    test_back_to_back();
    test_lock_idle();
    test_reset_mid_lock();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbiter and sequencer for the single data memory behind the MEM stage. It shares that memory between two requesters: the pipeline MEM stage (port `cpu`) and an external loader/debug master (port `dbg`). The pipeline has priority. A starvation counter guarantees `dbg` forward progress, and a lock lets `dbg` hold the memory across a multi-word burst. Load/store sign and width formatting stays in the MEM stage; this block moves only full 32-bit words.

## Interface
- `ADDR`, 32, address width.
- `DATA`, 32, data width.
- `STARVE_LIMIT`, 4, number of consecutive denied `dbg` cycles before `dbg` overrides `cpu`. Must be ≥1.

- `clk`  in  1  clock. All state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cpu_req`  in  1  MEM stage requests an access this cycle.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  ADDR  access address.
- `cpu_wd`  in  DATA  write data.
- `cpu_stall`  out  1  `cpu_req` present but not granted; the pipeline must hold.
- `cpu_rd`  out  DATA  registered read data.
- `cpu_rvalid`  out  1  `cpu_rd` is valid this cycle.
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wd`  in  1/1/ADDR/DATA  same meaning as the `cpu` inputs.
- `dbg_lock`  in  1  keep ownership after this access.
- `dbg_gnt`  out  1  `dbg` access accepted this cycle.
- `dbg_rd`  out  DATA  registered read data.
- `dbg_rvalid`  out  1  `dbg_rd` is valid this cycle.
- `mem_we`  out  1  memory write enable.
- `mem_wa`, `mem_ra`  out  ADDR  memory write and read addresses. Both carry the granted address.
- `mem_wd`  out  DATA  memory write data.
- `mem_rd`  in  DATA  memory read data, combinational from `mem_ra`.

## Operation
- At most one access per cycle. An access is accepted in cycle N when its requester's grant is high in cycle N.
- **Write:** `mem_we`=1 in cycle N. Memory captures the write at the end of cycle N.
- **Read:** `mem_ra` is driven in cycle N. `mem_rd` is registered at the end of cycle N. The owner's `*_rvalid`=1 in cycle N+1 only, and `*_rd` holds its value until the next read for that port.
- **FSM states:**
  - `S_ARB`: per-cycle arbitration.
  - `S_LOCK`: `dbg` owns the memory.
- **In `S_ARB`:**
  - The `dbg` grant is `dbg_req & (~cpu_req | starve_cnt==STARVE_LIMIT)`.
  - The `cpu` grant is `cpu_req & ~dbg_gnt`.
  - Transition to `S_LOCK` when `dbg_gnt & dbg_lock`.
- **In `S_LOCK`:**
  - `dbg_gnt` = `dbg_req`, and the `cpu` grant is 0.
  - Leave to `S_ARB` after the cycle in which `dbg_lock`=0. That cycle's `dbg` access, if any, is still granted.
  - Idle cycles (`dbg_req`=0, `dbg_lock`=1) keep the lock.
- `cpu_stall` = `cpu_req & ~cpu_grant`.
- **`starve_cnt`:**
  - Width `$clog2(STARVE_LIMIT+1)`.
  - Increments when `dbg_req & ~dbg_gnt`, saturating at `STARVE_LIMIT`.
  - Clears to 0 when `dbg_gnt` or `~dbg_req`.
- **Memory-side muxing:**
  - `mem_wa`/`mem_ra`/`mem_wd` come from the `dbg` inputs when `dbg_gnt`, otherwise from the `cpu` inputs.
  - `mem_we` = `(cpu_grant & cpu_we) | (dbg_gnt & dbg_we)`.
- **Boundaries:**
  - Simultaneous requests with the counter below the limit: `cpu` wins.
  - At the limit: `dbg` wins for exactly one access, unless it also asserts `dbg_lock`.
  - Requests deasserted mid-lock are simply idle cycles.
  - No requests: `mem_we`=0, and addresses follow `cpu_addr`.

## Timing
- **While `rst`=1:**
  - All grants are forced to 0.
  - `mem_we`=0, `cpu_stall`=0, `dbg_gnt`=0.
- **After the reset edge:**
  - State = `S_ARB`, `starve_cnt`=0.
  - `cpu_rvalid`=`dbg_rvalid`=0.
  - `cpu_rd`=`dbg_rd`=0.
- **Reset mid-lock or mid-read:** returns to `S_ARB`. A pending `rvalid` is dropped.
- **Latency:** a write takes effect at the end of the accept cycle. Read data is valid one cycle after accept.
- Grant/stall/mem outputs are combinational from the current state, counter and requests. There is no combinational path from `mem_rd` to any output.
- Back-to-back reads on one port give `rvalid` high on consecutive cycles.

## Test plan
- **Idle to `cpu` read:** after reset, `cpu` reads address 0x10 holding 0xDEADBEEF. Required: `cpu_stall`=0, `cpu_rd`=0xDEADBEEF with `cpu_rvalid` in the next cycle, `dbg_rvalid`=0.
- **Starvation:** `cpu_req` held continuously while `dbg` requests a write of 0x1234 to 0x40. Required: `dbg_gnt` in the 5th cycle, `cpu_stall`=1 in exactly that cycle, and a readback of 0x40 returns 0x1234.
- **Lock burst:** `dbg` writes 0x0,0x4,0x8,0xC with `dbg_lock`=1 on the first three accesses and 0 on the last, while `cpu` requests throughout. Required: `cpu_stall`=1 for all 4 cycles, then the `cpu` grant in the 5th cycle.
- **Lock idle gap:** lock held, `dbg_req` low for 3 cycles. Required: `cpu_stall` stays 1 and `mem_we`=0 throughout.
- **Reset mid-lock:** `rst` asserted during a burst. Required: `mem_we`=0 and grants 0 while `rst`=1, no `rvalid` after reset, and `cpu` is granted in the first cycle after `rst` deasserts.
